// File: rtl/systolic_pkg.sv
// Shared types, default sizes and the product-extension helper for the systolic matrix multiplier.
package systolic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int ROWS_DEF       = 4;
  localparam int COLS_DEF       = 4;
  localparam int DATA_WIDTH_DEF = 8;
  localparam int ACC_WIDTH_DEF  = 32;
  localparam int K_MAX_DEF      = 255;
  localparam int EXT_W          = 64;

  // Widens a prod_w-bit product to EXT_W bits, sign- or zero-filling above bit prod_w-1.
  function automatic logic [EXT_W-1:0] extend_product(input logic [EXT_W-1:0] prod,
                                                      input int prod_w,
                                                      input logic is_signed);
    logic [EXT_W-1:0] mask_v;
    logic             sign_v;
    mask_v = (64'd1 << prod_w) - 64'd1;
    sign_v = is_signed & (|(prod & (64'd1 << (prod_w - 1))));
    if (sign_v) begin
      extend_product = prod | ~mask_v;
    end else begin
      extend_product = prod & mask_v;
    end
  endfunction

endpackage

// File: rtl/systolic_matmul_pe.sv
// One multiply-accumulate cell: forwards a right and b down through one register each.
module systolic_pe
  import systolic_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ACC_WIDTH  = ACC_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  signed_mode,
  input  logic                  acc_clr,
  input  logic [DATA_WIDTH-1:0] a_in,
  input  logic [DATA_WIDTH-1:0] b_in,
  output logic [DATA_WIDTH-1:0] a_out,
  output logic [DATA_WIDTH-1:0] b_out,
  output logic [ACC_WIDTH-1:0]  acc
);

  localparam int PW = 2 * DATA_WIDTH;

  logic [PW-1:0]         a_ext_s;
  logic [PW-1:0]         b_ext_s;
  logic [PW-1:0]         mul_s;
  logic [DATA_WIDTH-1:0] a_r;
  logic [DATA_WIDTH-1:0] b_r;
  logic [ACC_WIDTH-1:0]  acc_r;

  // Low PW bits of the product of PW-bit extended operands are exact for both signednesses.
  assign a_ext_s = {{(PW - DATA_WIDTH){signed_mode & a_in[DATA_WIDTH-1]}}, a_in};
  assign b_ext_s = {{(PW - DATA_WIDTH){signed_mode & b_in[DATA_WIDTH-1]}}, b_in};
  assign mul_s   = a_ext_s * b_ext_s;

  // Forwarding registers and wrapping accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r   <= '0;
      b_r   <= '0;
      acc_r <= '0;
    end else begin
      a_r <= a_in;
      b_r <= b_in;
      if (acc_clr) begin
        acc_r <= '0;
      end else begin
        acc_r <= acc_r + ACC_WIDTH'(extend_product({{(EXT_W - PW){1'b0}}, mul_s}, PW, signed_mode));
      end
    end
  end

  assign a_out = a_r;
  assign b_out = b_r;
  assign acc   = acc_r;

endmodule

// File: rtl/systolic_matmul.sv
// Output-stationary ROWS x COLS systolic matrix multiplier with skewed operand injection.
module systolic_matmul
  import systolic_pkg::*;
#(
  parameter int ROWS       = ROWS_DEF,
  parameter int COLS       = COLS_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ACC_WIDTH  = ACC_WIDTH_DEF,
  parameter int K_MAX      = K_MAX_DEF
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       start,
  input  logic [$clog2(K_MAX+1)-1:0]                 k_len,
  input  logic                                       signed_mode,
  input  logic                                       acc_keep,
  input  logic                                       a_valid,
  output logic                                       a_ready,
  input  logic [ROWS-1:0][DATA_WIDTH-1:0]            a_data,
  input  logic [COLS-1:0][DATA_WIDTH-1:0]            b_data,
  output logic                                       res_valid,
  input  logic                                       res_ready,
  output logic [ROWS-1:0][COLS-1:0][ACC_WIDTH-1:0]   res_data,
  output logic                                       busy
);

  localparam int KW = $clog2(K_MAX + 1);
  localparam int CW = $clog2(ROWS + COLS);

  state_e          state_r;
  state_e          state_nx_s;
  logic [KW-1:0]   k_len_r;
  logic [KW-1:0]   k_len_clamp_s;
  logic [KW-1:0]   beat_cnt_r;
  logic [CW-1:0]   drain_cnt_r;
  logic            mode_r;
  logic            a_ready_r;
  logic            res_valid_r;
  logic            busy_r;
  logic            fire_s;
  logic            acc_clr_s;

  logic [DATA_WIDTH-1:0] a_h_s [ROWS][COLS+1];
  logic [DATA_WIDTH-1:0] b_v_s [ROWS+1][COLS];
  logic [ROWS-1:0]       a_tail_unused_s;
  logic [COLS-1:0]       b_tail_unused_s;

  assign fire_s    = a_valid & a_ready_r;
  assign acc_clr_s = (state_r == ST_IDLE) & start & ~acc_keep;

  // Clamp the requested reduction length to K_MAX.
  always_comb begin
    k_len_clamp_s = k_len;
    if (k_len > KW'(K_MAX)) begin
      k_len_clamp_s = KW'(K_MAX);
    end else begin
      k_len_clamp_s = k_len;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          if (k_len_clamp_s == '0) begin
            state_nx_s = ST_DONE;
          end else begin
            state_nx_s = ST_LOAD;
          end
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (fire_s && (beat_cnt_r == k_len_r - KW'(1))) begin
          state_nx_s = ST_DRAIN;
        end else begin
          state_nx_s = ST_LOAD;
        end
      end
      ST_DRAIN: begin
        if (drain_cnt_r == CW'(ROWS + COLS - 2)) begin
          state_nx_s = ST_DONE;
        end else begin
          state_nx_s = ST_DRAIN;
        end
      end
      ST_DONE: begin
        if (res_ready) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_DONE;
        end
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // State, job parameters, counters and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      k_len_r     <= '0;
      mode_r      <= 1'b0;
      beat_cnt_r  <= '0;
      drain_cnt_r <= '0;
      a_ready_r   <= 1'b0;
      res_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      a_ready_r   <= (state_nx_s == ST_LOAD);
      res_valid_r <= (state_nx_s == ST_DONE);
      busy_r      <= (state_nx_s != ST_IDLE);
      if ((state_r == ST_IDLE) && start) begin
        k_len_r <= k_len_clamp_s;
        mode_r  <= signed_mode;
      end
      if (state_r == ST_IDLE) begin
        beat_cnt_r <= '0;
      end else if (fire_s) begin
        beat_cnt_r <= beat_cnt_r + KW'(1);
      end
      if (state_r == ST_DRAIN) begin
        drain_cnt_r <= drain_cnt_r + CW'(1);
      end else begin
        drain_cnt_r <= '0;
      end
    end
  end

  assign a_ready   = a_ready_r;
  assign res_valid = res_valid_r;
  assign busy      = busy_r;

  // Row i of A enters i cycles late; idle cycles inject zeros.
  for (genvar i = 0; i < ROWS; i++) begin : g_row_skew
    logic [DATA_WIDTH-1:0] inj_s;
    assign inj_s = fire_s ? a_data[i] : '0;
    if (i == 0) begin : g_direct
      assign a_h_s[i][0] = inj_s;
    end else begin : g_delay
      logic [DATA_WIDTH-1:0] dly_r [i];
      // Delay line for row i.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int d = 0; d < i; d++) dly_r[d] <= '0;
        end else begin
          dly_r[0] <= inj_s;
          for (int d = 1; d < i; d++) dly_r[d] <= dly_r[d-1];
        end
      end
      assign a_h_s[i][0] = dly_r[i-1];
    end
    assign a_tail_unused_s[i] = ^a_h_s[i][COLS];
  end

  for (genvar j = 0; j < COLS; j++) begin : g_col_skew
    logic [DATA_WIDTH-1:0] inj_s;
    assign inj_s = fire_s ? b_data[j] : '0;
    if (j == 0) begin : g_direct
      assign b_v_s[0][j] = inj_s;
    end else begin : g_delay
      logic [DATA_WIDTH-1:0] dly_r [j];
      // Delay line for column j.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int d = 0; d < j; d++) dly_r[d] <= '0;
        end else begin
          dly_r[0] <= inj_s;
          for (int d = 1; d < j; d++) dly_r[d] <= dly_r[d-1];
        end
      end
      assign b_v_s[0][j] = dly_r[j-1];
    end
    assign b_tail_unused_s[j] = ^b_v_s[ROWS][j];
  end

  for (genvar i = 0; i < ROWS; i++) begin : g_pe_row
    for (genvar j = 0; j < COLS; j++) begin : g_pe_col
      systolic_pe #(
        .DATA_WIDTH(DATA_WIDTH),
        .ACC_WIDTH (ACC_WIDTH)
      ) u_pe (
        .clk        (clk),
        .rst_n      (rst_n),
        .signed_mode(mode_r),
        .acc_clr    (acc_clr_s),
        .a_in       (a_h_s[i][j]),
        .b_in       (b_v_s[i][j]),
        .a_out      (a_h_s[i][j+1]),
        .b_out      (b_v_s[i+1][j]),
        .acc        (res_data[i][j])
      );
    end
  end

endmodule

// File: tb/tb_systolic_matmul.sv
// Randomized and directed bench for systolic_matmul against a plain matrix-product model.
module tb_systolic_matmul;

  localparam int R    = 3;
  localparam int C    = 3;
  localparam int DW   = 8;
  localparam int AW   = 32;
  localparam int KMAX = 255;
  localparam int KW   = 8;
  localparam int KBUF = 64;

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b0;
  logic                      start = 1'b0;
  logic [KW-1:0]             k_len = '0;
  logic                      signed_mode = 1'b0;
  logic                      acc_keep = 1'b0;
  logic                      a_valid = 1'b0;
  logic                      a_ready;
  logic [R-1:0][DW-1:0]      a_data = '0;
  logic [C-1:0][DW-1:0]      b_data = '0;
  logic                      res_valid;
  logic                      res_ready = 1'b0;
  logic [R-1:0][C-1:0][AW-1:0] res_data;
  logic                      busy;

  int n_vec = 0;
  int n_err = 0;

  logic [DW-1:0] ma [R][KBUF];
  logic [DW-1:0] mb [KBUF][C];
  logic [AW-1:0] mc [R][C];

  systolic_matmul #(
    .ROWS(R), .COLS(C), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .K_MAX(KMAX)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len),
    .signed_mode(signed_mode), .acc_keep(acc_keep),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data), .b_data(b_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic longint opnd(input logic [DW-1:0] v, input bit sgn);
    if (sgn) return longint'($signed(v));
    else return longint'(v);
  endfunction

  // C = A*B (+ C when keeping), modulo 2^AW
  task automatic model_job(input int k, input bit sgn, input bit keep);
    logic [AW-1:0] s;
    for (int i = 0; i < R; i++) begin
      for (int j = 0; j < C; j++) begin
        s = keep ? mc[i][j] : '0;
        for (int kk = 0; kk < k; kk++) s = s + AW'(opnd(ma[i][kk], sgn) * opnd(mb[kk][j], sgn));
        mc[i][j] = s;
      end
    end
  endtask

  task automatic check_result(input string tag);
    for (int i = 0; i < R; i++)
      for (int j = 0; j < C; j++)
        check_val($sformatf("%s c%0d%0d", tag, i, j), 64'(res_data[i][j]), 64'(mc[i][j]));
  endtask

  task automatic set_ident_b();
    for (int i = 0; i < R; i++)
      for (int k = 0; k < KBUF; k++) ma[i][k] = (i == k) ? 8'd1 : 8'd0;
    for (int k = 0; k < KBUF; k++)
      for (int j = 0; j < C; j++) mb[k][j] = (k < 3) ? DW'(k * 3 + j + 1) : 8'd0;
  endtask

  task automatic fill_const(input logic [DW-1:0] av, input logic [DW-1:0] bv);
    for (int i = 0; i < R; i++) for (int k = 0; k < KBUF; k++) ma[i][k] = av;
    for (int k = 0; k < KBUF; k++) for (int j = 0; j < C; j++) mb[k][j] = bv;
  endtask

  task automatic fill_rand();
    for (int i = 0; i < R; i++) for (int k = 0; k < KBUF; k++) ma[i][k] = DW'($urandom);
    for (int k = 0; k < KBUF; k++) for (int j = 0; j < C; j++) mb[k][j] = DW'($urandom);
  endtask

  task automatic drive_beat(input int beat);
    for (int i = 0; i < R; i++) a_data[i] = ma[i][beat];
    for (int j = 0; j < C; j++) b_data[j] = mb[beat][j];
  endtask

  task automatic drive_junk();
    for (int i = 0; i < R; i++) a_data[i] = DW'($urandom);
    for (int j = 0; j < C; j++) b_data[j] = DW'($urandom);
  endtask

  // Called #1 after a rising edge with the DUT idle; returns it to idle.
  task automatic run_job(input string tag, input int k, input bit sgn, input bit keep,
                         input int gap_beat, input int gap_len, input bit rnd_gap, input int hold);
    int  beat;
    int  gapcnt;
    int  guard;
    int  lat;
    bit  idle;
    bit  fire;
    start = 1'b1; k_len = KW'(k); signed_mode = sgn; acc_keep = keep;
    @(posedge clk); #1;
    start = 1'b0; k_len = KW'($urandom); signed_mode = 1'($urandom); acc_keep = 1'($urandom);
    model_job(k, sgn, keep);
    check_val({tag, " busy"}, 64'(busy), 64'(1));
    check_val({tag, " a_ready"}, 64'(a_ready), 64'(k > 0));
    beat = 0; gapcnt = 0; guard = 0;
    while (beat < k && guard < 2000) begin
      idle = (beat == gap_beat && gapcnt < gap_len) || (rnd_gap && $urandom_range(0, 3) == 0);
      a_valid = !idle;
      if (idle) drive_junk();
      else drive_beat(beat);
      fire = a_valid && a_ready;
      @(posedge clk); #1;
      guard++;
      if (fire) beat++;
      else if (idle) gapcnt++;
    end
    if (k > 0) check_val({tag, " beats"}, 64'(beat), 64'(k));
    a_valid = 1'b0;
    drive_junk();
    lat = 0;
    while (!res_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    check_val({tag, " latency"}, 64'(lat), 64'((k == 0) ? 0 : R + C - 1));
    check_result(tag);
    for (int h = 0; h < hold; h++) begin
      start = (h == 1); k_len = '0; acc_keep = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      check_val({tag, " hold valid"}, 64'(res_valid), 64'(1));
      check_val({tag, " hold busy"}, 64'(busy), 64'(1));
      check_val({tag, " hold c11"}, 64'(res_data[1][1]), 64'(mc[1][1]));
    end
    if (hold > 0) check_result({tag, " held"});
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    check_val({tag, " idle busy"}, 64'(busy), 64'(0));
    check_val({tag, " idle valid"}, 64'(res_valid), 64'(0));
  endtask

  initial begin
    for (int i = 0; i < R; i++) for (int j = 0; j < C; j++) mc[i][j] = '0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst a_ready", 64'(a_ready), 64'(0));
    check_val("rst res_valid", 64'(res_valid), 64'(0));
    check_val("rst busy", 64'(busy), 64'(0));
    check_val("rst res_data", 64'(|res_data), 64'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    set_ident_b();
    run_job("ident", 3, 1'b0, 1'b0, -1, 0, 1'b0, 0);
    check_val("ident c22 const", 64'(res_data[2][2]), 64'(9));
    run_job("keep", 3, 1'b0, 1'b1, -1, 0, 1'b0, 0);
    check_val("keep c01 const", 64'(res_data[0][1]), 64'(4));
    run_job("clear", 3, 1'b0, 1'b0, -1, 0, 1'b0, 0);
    run_job("gap", 3, 1'b0, 1'b0, 1, 2, 1'b0, 0);
    run_job("k0 keep", 0, 1'b0, 1'b1, -1, 0, 1'b0, 0);
    run_job("k0 clr", 0, 1'b0, 1'b0, -1, 0, 1'b0, 0);

    fill_const(8'hFF, 8'd2);
    run_job("neg", 3, 1'b1, 1'b0, -1, 0, 1'b0, 0);
    check_val("neg const", 64'(res_data[2][0]), 64'(32'hFFFF_FFFA));
    run_job("uns", 3, 1'b0, 1'b0, -1, 0, 1'b0, 0);
    check_val("uns const", 64'(res_data[0][2]), 64'(1530));

    set_ident_b();
    run_job("hold", 3, 1'b0, 1'b0, -1, 0, 1'b0, 5);
    @(posedge clk); #1;
    check_val("idle retain c12", 64'(res_data[1][2]), 64'(mc[1][2]));
    check_val("idle no job", 64'(busy), 64'(0));

    // abort mid-load with an asynchronous reset
    start = 1'b1; k_len = 8'd3; acc_keep = 1'b0; signed_mode = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    a_valid = 1'b1; drive_beat(0);
    @(posedge clk); #1;
    drive_beat(1);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("abort a_ready", 64'(a_ready), 64'(0));
    check_val("abort res_valid", 64'(res_valid), 64'(0));
    check_val("abort busy", 64'(busy), 64'(0));
    check_val("abort res_data", 64'(|res_data), 64'(0));
    a_valid = 1'b0;
    for (int i = 0; i < R; i++) for (int j = 0; j < C; j++) mc[i][j] = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_job("post rst", 3, 1'b0, 1'b0, -1, 0, 1'b0, 0);

    for (int n = 0; n < 10; n++) begin
      fill_rand();
      run_job($sformatf("rand%0d", n), $urandom_range(1, 8), 1'($urandom), 1'($urandom),
              -1, 0, 1'b1, $urandom_range(0, 2));
    end
    fill_rand();
    run_job("long", 40, 1'b1, 1'b1, 5, 3, 1'b1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
